// File: rtl/qmca_trig_ctrl.sv
// Trigger sequencer for the qMCA pulse-height path: one trigger per pulse with
// threshold hysteresis, hold-off, peak capture, accepted/missed counting and a trigger limit.
module qmca_trig_ctrl #(
    parameter int ADC_WIDTH  = 14,
    parameter int HOLD_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENABLE,
    input  logic [ADC_WIDTH-1:0]  ADC_IN,
    input  logic [ADC_WIDTH-1:0]  TH,
    input  logic [ADC_WIDTH-1:0]  HYST,
    input  logic [HOLD_WIDTH-1:0] HOLDOFF,
    input  logic [15:0]           MAX_TRIG,
    input  logic                  RX_BUSY,
    output logic                  TRIGGER,
    output logic [ADC_WIDTH-1:0]  PEAK,
    output logic                  PEAK_VALID,
    output logic [15:0]           TRIG_CNT,
    output logic [15:0]           MISSED_CNT,
    output logic [2:0]            STATE,
    output logic                  DONE
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_ABOVE = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  below_q, below_d;
    logic [ADC_WIDTH-1:0]  run_peak_q, run_peak_d;
    logic [ADC_WIDTH-1:0]  peak_q, peak_d;
    logic                  trigger_q, trigger_d;
    logic                  peak_valid_q, peak_valid_d;
    logic [15:0]           trig_cnt_q, trig_cnt_d;
    logic [15:0]           missed_cnt_q, missed_cnt_d;
    logic [HOLD_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic                  done_q, done_d;
    logic [ADC_WIDTH-1:0]  tl;

    assign tl = (TH > HYST) ? TH - HYST : '0;

    always_comb begin
        state_d      = state_q;
        below_d      = below_q;
        run_peak_d   = run_peak_q;
        peak_d       = peak_q;
        trigger_d    = 1'b0;
        peak_valid_d = 1'b0;
        trig_cnt_d   = trig_cnt_q;
        missed_cnt_d = missed_cnt_q;
        hold_cnt_d   = hold_cnt_q;

        if (!ENABLE) begin
            // Disabling drops any pulse in progress; counters are left for software to read.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d      = S_ARMED;
                    trig_cnt_d   = '0;
                    missed_cnt_d = '0;
                    below_d      = 1'b0;
                end
                S_ARMED: begin
                    if (ADC_IN > TH && below_q) begin
                        if (!RX_BUSY) begin
                            trigger_d  = 1'b1;
                            trig_cnt_d = trig_cnt_q + 16'd1;
                            run_peak_d = ADC_IN;
                            state_d    = S_ABOVE;
                        end else begin
                            if (missed_cnt_q != '1)
                                missed_cnt_d = missed_cnt_q + 16'd1;
                            below_d = 1'b0;
                        end
                    end else if (ADC_IN <= tl) begin
                        below_d = 1'b1;
                    end
                end
                S_ABOVE: begin
                    if (ADC_IN > tl) begin
                        if (ADC_IN > run_peak_q)
                            run_peak_d = ADC_IN;
                    end else begin
                        peak_valid_d = 1'b1;
                        peak_d       = run_peak_q;
                        if (MAX_TRIG != '0 && trig_cnt_q == MAX_TRIG) begin
                            state_d = S_DONE;
                        end else if (HOLDOFF != '0) begin
                            state_d    = S_HOLD;
                            hold_cnt_d = HOLDOFF;
                        end else begin
                            // The fall sample is already below TL, so re-arm immediately.
                            state_d = S_ARMED;
                            below_d = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    // <= 1 rather than == 1 so a zero count can never stall here.
                    if (hold_cnt_q <= HOLD_WIDTH'(1)) begin
                        state_d = S_ARMED;
                        below_d = 1'b0;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_WIDTH'(1);
                    end
                end
                S_DONE: state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            below_q      <= 1'b0;
            run_peak_q   <= '0;
            peak_q       <= '0;
            trigger_q    <= 1'b0;
            peak_valid_q <= 1'b0;
            trig_cnt_q   <= '0;
            missed_cnt_q <= '0;
            hold_cnt_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            below_q      <= below_d;
            run_peak_q   <= run_peak_d;
            peak_q       <= peak_d;
            trigger_q    <= trigger_d;
            peak_valid_q <= peak_valid_d;
            trig_cnt_q   <= trig_cnt_d;
            missed_cnt_q <= missed_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            done_q       <= done_d;
        end
    end

    assign TRIGGER    = trigger_q;
    assign PEAK       = peak_q;
    assign PEAK_VALID = peak_valid_q;
    assign TRIG_CNT   = trig_cnt_q;
    assign MISSED_CNT = missed_cnt_q;
    assign STATE      = state_q;
    assign DONE       = done_q;

endmodule

// File: doc/qmca_trig_ctrl.md
# qmca_trig_ctrl

Trigger sequencer for the qMCA pulse-height datapath. It runs in the ADC encoder domain on the selected ADC channel's samples. It issues exactly one trigger per pulse to the ADC receiver, applying threshold hysteresis and a programmable hold-off, and reports each pulse's peak amplitude. It counts accepted and missed pulses and stops after a programmable number of triggers.

## Interface
Parameters:
- ADC_WIDTH, 14, sample/threshold width
- HOLD_WIDTH, 16, hold-off counter width

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  ADC encoder clock; one sample per cycle
- RST  in  1  synchronous active-high reset
- ENABLE  in  1  run enable; level-sensitive
- ADC_IN  in  ADC_WIDTH  current sample, unsigned
- TH  in  ADC_WIDTH  trigger threshold, unsigned
- HYST  in  ADC_WIDTH  hysteresis; re-arm level TL = (TH > HYST) ? TH-HYST : 0
- HOLDOFF  in  HOLD_WIDTH  dead cycles after each pulse; 0 = none
- MAX_TRIG  in  16  stop after this many triggers; 0 = unlimited
- RX_BUSY  in  1  receiver still recording previous trigger
- TRIGGER  out  1  single-cycle trigger to receiver
- PEAK  out  ADC_WIDTH  max sample of last pulse; held until next PEAK_VALID
- PEAK_VALID  out  1  single-cycle, PEAK updated
- TRIG_CNT  out  16  accepted triggers
- MISSED_CNT  out  16  crossings rejected due to RX_BUSY, saturating at 0xFFFF
- STATE  out  3  current state encoding
- DONE  out  1  high while in DONE

## Operation
- States (STATE encoding): IDLE=0, ARMED=1, ABOVE=2, HOLD=3, DONE=4.
- ENABLE=0 in any state: next state IDLE. Any pulse in progress is dropped, with no PEAK_VALID. Counters keep their values.
- IDLE, ENABLE=1: go to ARMED and clear TRIG_CNT, MISSED_CNT and the internal flag below_seen.
- below_seen: set in ARMED when ADC_IN <= TL. A signal already high at enable never triggers.
- ARMED, ADC_IN > TH and below_seen=1:
  - RX_BUSY=0: TRIGGER, TRIG_CNT+1, peak register := ADC_IN, go to ABOVE.
  - RX_BUSY=1: MISSED_CNT+1, clear below_seen, stay ARMED.
- ABOVE:
  - While ADC_IN > TL: peak := max(peak, ADC_IN).
  - First sample with ADC_IN <= TL: PEAK_VALID, PEAK := peak.
  - Next state after that sample: DONE if MAX_TRIG≠0 and TRIG_CNT==MAX_TRIG; else HOLD if HOLDOFF≠0; else ARMED with below_seen=1.
- HOLD: count down HOLDOFF cycles, ignoring ADC_IN. Then go to ARMED with below_seen=0.
- DONE: remains until ENABLE=0.
- TRIG_CNT wraps only if MAX_TRIG=0. Comparisons are unsigned and full width.
- TH, HYST, HOLDOFF and MAX_TRIG are sampled every cycle. Software changes them only while ENABLE=0; changes made while enabled are undefined but must not lock the state machine.

## Timing
- All outputs are registered.
- Reset values: TRIGGER=0, PEAK_VALID=0, PEAK=0, TRIG_CNT=0, MISSED_CNT=0, STATE=IDLE, DONE=0.
- TRIGGER is high exactly in cycle n+1 when the crossing sample is presented in cycle n.
- PEAK_VALID and PEAK update in cycle m+1 for the falling sample in cycle m.
- HOLD lasts exactly HOLDOFF cycles. The first sample that can set below_seen arrives HOLDOFF+1 cycles after the falling sample.
- Minimum trigger spacing with HOLDOFF=0: crossing, fall, then one ARMED cycle. The cycle after the fall is already ARMED and can trigger.
- RX_BUSY is sampled in the crossing cycle only.
- RST has priority over ENABLE. RST mid-pulse returns to IDLE next cycle with no PEAK_VALID.
- A fall and ENABLE=0 in the same cycle: ENABLE wins and no PEAK_VALID is issued.

## Test plan
- Basic pulse: TH=1000, HYST=100, HOLDOFF=0. ADC_IN sequence 0,1200,3000,2500,850,0 → one TRIGGER the cycle after 1200; PEAK_VALID with PEAK=3000 the cycle after 850; TRIG_CNT=1.
- Hysteresis: same settings, ADC_IN 0,1200,950,1100,850 → one TRIGGER only; PEAK=1200; ringing at 950/1100 ignored.
- High at enable: ADC_IN held at 2000 when ENABLE rises → no TRIGGER until ADC_IN ≤ 900 and then > 1000 again.
- Busy receiver: RX_BUSY=1 during crossing → no TRIGGER, MISSED_CNT=1. A later crossing with RX_BUSY=0 after going below TL → TRIGGER, TRIG_CNT=1.
- Hold-off and limit: HOLDOFF=5, MAX_TRIG=2, three back-to-back pulses → the second trigger is not earlier than 6 cycles after the first fall; after the second PEAK_VALID, STATE=DONE and DONE=1; the third pulse gives no TRIGGER. ENABLE low then high → IDLE, then ARMED with counters cleared.
- Abort: ENABLE=0 (or RST=1) during ABOVE → STATE=IDLE next cycle, no PEAK_VALID, PEAK retains its previous value (0 after RST).
